// File: rtl/ru_data_wr_mux.sv
// Register-unit write-back data selector: combinational DataWr plus a registered
// write-back record. Define RUDATAWR_STATS_EN to add per-source usage counters.
module ru_data_wr_mux #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            RUDataWrSrc,
    input  logic [XLEN-1:0]       ALURes,
    input  logic [XLEN-1:0]       DataRd,
    input  logic [XLEN-1:0]       PC_with_offset,
    input  logic                  RUWr,
    input  logic [REG_ADDR_W-1:0] rd,
    output logic [XLEN-1:0]       DataWr,
    output logic [XLEN-1:0]       WbData_q,
    output logic [REG_ADDR_W-1:0] WbRd_q,
    output logic                  WbValid_q,
    output logic                  SelErr_q
`ifdef RUDATAWR_STATS_EN
    ,
    output logic [31:0]           CntAlu,
    output logic [31:0]           CntMem,
    output logic [31:0]           CntPc,
    output logic [31:0]           CntRsv
`endif
);

    logic wb_valid_d;
    logic sel_err_d;

    // Reserved and unknown selects both fall to the default arm and yield zero.
    always_comb begin
        DataWr = '0;
        case (RUDataWrSrc)
            2'b00:   DataWr = ALURes;
            2'b01:   DataWr = DataRd;
            2'b10:   DataWr = PC_with_offset;
            default: DataWr = '0;
        endcase
    end

    always_comb begin
        wb_valid_d = RUWr && (rd != '0);
        sel_err_d  = SelErr_q || (RUWr && (RUDataWrSrc == 2'b11));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            WbData_q  <= '0;
            WbRd_q    <= '0;
            WbValid_q <= 1'b0;
            SelErr_q  <= 1'b0;
        end else begin
            WbData_q  <= DataWr;
            WbRd_q    <= rd;
            WbValid_q <= wb_valid_d;
            SelErr_q  <= sel_err_d;
        end
    end

`ifdef RUDATAWR_STATS_EN
    logic [31:0] cnt_alu_d, cnt_mem_d, cnt_pc_d, cnt_rsv_d;

    // Counters wrap naturally at 32 bits.
    always_comb begin
        cnt_alu_d = CntAlu;
        cnt_mem_d = CntMem;
        cnt_pc_d  = CntPc;
        cnt_rsv_d = CntRsv;
        if (RUWr) begin
            case (RUDataWrSrc)
                2'b00:   cnt_alu_d = CntAlu + 32'd1;
                2'b01:   cnt_mem_d = CntMem + 32'd1;
                2'b10:   cnt_pc_d  = CntPc + 32'd1;
                default: cnt_rsv_d = CntRsv + 32'd1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            CntAlu <= '0;
            CntMem <= '0;
            CntPc  <= '0;
            CntRsv <= '0;
        end else begin
            CntAlu <= cnt_alu_d;
            CntMem <= cnt_mem_d;
            CntPc  <= cnt_pc_d;
            CntRsv <= cnt_rsv_d;
        end
    end
`endif

endmodule

// File: tb/tb_ru_data_wr_mux.sv
// Bench for ru_data_wr_mux: directed literal checks, then randomized stimulus compared
// every cycle against a table-lookup model of the write-back rules.
module tb_ru_data_wr_mux;

    logic        clk;
    logic        rst;
    logic        clk_run;
    logic [1:0]  RUDataWrSrc;
    logic [31:0] ALURes;
    logic [31:0] DataRd;
    logic [31:0] PC_with_offset;
    logic        RUWr;
    logic [4:0]  rd;
    logic [31:0] DataWr;
    logic [31:0] WbData_q;
    logic [4:0]  WbRd_q;
    logic        WbValid_q;
    logic        SelErr_q;
`ifdef RUDATAWR_STATS_EN
    logic [31:0] CntAlu, CntMem, CntPc, CntRsv;
`endif

    ru_data_wr_mux #(
        .XLEN       (32),
        .REG_ADDR_W (5)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .RUDataWrSrc    (RUDataWrSrc),
        .ALURes         (ALURes),
        .DataRd         (DataRd),
        .PC_with_offset (PC_with_offset),
        .RUWr           (RUWr),
        .rd             (rd),
        .DataWr         (DataWr),
        .WbData_q       (WbData_q),
        .WbRd_q         (WbRd_q),
        .WbValid_q      (WbValid_q),
        .SelErr_q       (SelErr_q)
`ifdef RUDATAWR_STATS_EN
        ,
        .CntAlu         (CntAlu),
        .CntMem         (CntMem),
        .CntPc          (CntPc),
        .CntRsv         (CntRsv)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: the last accepted write-back record.
    logic [31:0] m_data  = '0;
    logic [4:0]  m_rd    = '0;
    logic        m_valid = 1'b0;
    logic        m_err   = 1'b0;
    logic [31:0] m_cnt [4] = '{default: 32'd0};
    logic        cmp_en  = 1'b0;

    initial begin
        clk = 1'b0;
        forever begin
            #5;
            if (clk_run) clk = ~clk;
        end
    end

    function automatic logic [31:0] sel_word(logic [1:0] s, logic [31:0] a, logic [31:0] d,
                                             logic [31:0] p);
        logic [31:0] tbl [4];
        tbl[0] = a;
        tbl[1] = d;
        tbl[2] = p;
        tbl[3] = 32'h0;
        return tbl[s];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            m_data  <= sel_word(RUDataWrSrc, ALURes, DataRd, PC_with_offset);
            m_rd    <= rd;
            m_valid <= RUWr && (rd != 5'd0);
            if (RUWr && RUDataWrSrc == 2'b11) m_err <= 1'b1;
            if (RUWr) m_cnt[RUDataWrSrc] <= m_cnt[RUDataWrSrc] + 32'd1;
        end
    end

    always @(posedge rst) begin
        m_data  <= '0;
        m_rd    <= '0;
        m_valid <= 1'b0;
        m_err   <= 1'b0;
        m_cnt   <= '{default: 32'd0};
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_datawr", DataWr, sel_word(RUDataWrSrc, ALURes, DataRd, PC_with_offset));
            chk("cyc_wbdata", WbData_q, m_data);
            chk("cyc_wbrd", {27'd0, WbRd_q}, {27'd0, m_rd});
            chk("cyc_wbvalid", {31'd0, WbValid_q}, {31'd0, m_valid});
            chk("cyc_selerr", {31'd0, SelErr_q}, {31'd0, m_err});
`ifdef RUDATAWR_STATS_EN
            chk("cyc_cntalu", CntAlu, m_cnt[0]);
            chk("cyc_cntmem", CntMem, m_cnt[1]);
            chk("cyc_cntpc", CntPc, m_cnt[2]);
            chk("cyc_cntrsv", CntRsv, m_cnt[3]);
`endif
        end
    end

    task automatic drive(logic [1:0] s, logic w, logic [4:0] r);
        RUDataWrSrc = s;
        RUWr        = w;
        rd          = r;
    endtask

    initial begin
        logic [31:0] sweep_exp [4];
        sweep_exp[0] = 32'h1234_5678;
        sweep_exp[1] = 32'hCAFE_BABE;
        sweep_exp[2] = 32'h0000_0040;
        sweep_exp[3] = 32'h0000_0000;

        clk_run        = 1'b0;
        rst            = 1'b1;
        ALURes         = 32'h1234_5678;
        DataRd         = 32'hCAFE_BABE;
        PC_with_offset = 32'h0000_0040;
        drive(2'b00, 1'b0, 5'd0);
        #1;
        chk("rst_wbdata", WbData_q, 32'h0);
        chk("rst_wbrd", {27'd0, WbRd_q}, 32'h0);
        chk("rst_wbvalid", {31'd0, WbValid_q}, 32'h0);
        chk("rst_selerr", {31'd0, SelErr_q}, 32'h0);

        // Select sweep with the clock stopped.
        for (int i = 0; i < 4; i++) begin
            RUDataWrSrc = 2'(i);
            #1;
            chk($sformatf("sweep_sel%0d", i), DataWr, sweep_exp[i]);
        end

        rst     = 1'b0;
        clk_run = 1'b1;
        cmp_en  = 1'b1;

        drive(2'b01, 1'b1, 5'd5);
        @(posedge clk); #1;
        chk("load_wbdata", WbData_q, 32'hCAFE_BABE);
        chk("load_wbrd", {27'd0, WbRd_q}, 32'd5);
        chk("load_wbvalid", {31'd0, WbValid_q}, 32'd1);

        drive(2'b00, 1'b1, 5'd0);
        @(posedge clk); #1;
        chk("x0_wbvalid", {31'd0, WbValid_q}, 32'd0);
        chk("x0_wbdata", WbData_q, 32'h1234_5678);

        drive(2'b11, 1'b1, 5'd7);
        @(posedge clk); #1;
        chk("rsv_selerr", {31'd0, SelErr_q}, 32'd1);
        chk("rsv_wbdata", WbData_q, 32'h0);
        drive(2'b00, 1'b1, 5'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("rsv_sticky", {31'd0, SelErr_q}, 32'd1);

        // Asynchronous reset between edges.
        rst = 1'b1;
        #1;
        chk("arst_wbdata", WbData_q, 32'h0);
        chk("arst_wbrd", {27'd0, WbRd_q}, 32'h0);
        chk("arst_selerr", {31'd0, SelErr_q}, 32'h0);
        chk("arst_datawr", DataWr, 32'h1234_5678);
        RUDataWrSrc = 2'b10;
        #1;
        chk("arst_datawr_pc", DataWr, 32'h0000_0040);
        #1;
        rst = 1'b0;

        drive(2'b10, 1'b1, 5'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("first_cap_wbdata", WbData_q, 32'h0000_0040);
        RUWr = 1'b0;
        @(posedge clk); #1;
        chk("first_cap_wbvalid", {31'd0, WbValid_q}, 32'd0);
`ifdef RUDATAWR_STATS_EN
        chk("stats_cntpc", CntPc, 32'd3);
        chk("stats_cntalu", CntAlu, 32'd0);
        chk("stats_cntmem", CntMem, 32'd0);
        chk("stats_cntrsv", CntRsv, 32'd0);
`endif

        // Randomized phase; occasional reset pulses land between edges.
        for (int n = 0; n < 2000; n++) begin
            @(posedge clk); #2;
            ALURes         = $urandom;
            DataRd         = $urandom;
            PC_with_offset = $urandom;
            RUDataWrSrc    = 2'($urandom_range(0, 3));
            RUWr           = ($urandom_range(0, 3) != 0);
            rd             = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
        end

        @(posedge clk); #1;
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ru_data_wr_mux.md
Name: ru_data_wr_mux

Overview:
Write-back data selector for the RISC-V single-cycle core's register unit (RU). It chooses the value written to the destination register from three sources: the ALU result, the data-memory read data, or PC+4 (PC_with_offset) for JAL/JALR. The selected word is available combinationally. A registered write-back record (data, rd, valid) is also provided for tracing and downstream pipelining.

Parameters:
XLEN, 32, datapath width of all data ports.
REG_ADDR_W, 5, width of the destination register index.

Ports:
clk  input  1  system clock.
rst  input  1  reset, asynchronous, active-high.
RUDataWrSrc  input  2  source select: 00 ALURes, 01 DataRd, 10 PC_with_offset, 11 reserved.
ALURes  input  XLEN  ALU result.
DataRd  input  XLEN  data-memory read data.
PC_with_offset  input  XLEN  PC+4 link value.
RUWr  input  1  register-unit write enable for the current instruction.
rd  input  REG_ADDR_W  destination register index.
DataWr  output  XLEN  selected write-back data, combinational.
WbData_q  output  XLEN  registered DataWr.
WbRd_q  output  REG_ADDR_W  registered rd.
WbValid_q  output  1  registered write strobe.
SelErr_q  output  1  sticky reserved-select flag.

Behaviour:
- Interface: one clock (clk); reset (rst) is asynchronous and active-high.
- DataWr is purely combinational, with zero latency and no dependence on clk or rst:
  - 00 -> ALURes
  - 01 -> DataRd
  - 10 -> PC_with_offset
  - 11 -> 32'h0000_0000
  - X or Z on the select also -> 0 (default arm).
- DataWr must settle within the same delta/timestep as an input change.
- Registered record, on posedge clk:
  - WbData_q <= DataWr
  - WbRd_q <= rd
  - WbValid_q <= RUWr && (rd != 0); writes to x0 are never flagged valid.
  - When RUWr=0, WbData_q and WbRd_q still update; only WbValid_q is 0.
- SelErr_q sets on any posedge where RUWr=1 and RUDataWrSrc=11. It holds until reset and is not cleared by later legal selects.
- Reset (asserted, asynchronous): WbData_q=0, WbRd_q=0, WbValid_q=0, SelErr_q=0, effective immediately without waiting for a clock edge. DataWr is unaffected by reset.
- Reset released mid-stream: the first capture occurs on the first posedge after deassertion.
- Simultaneous select change and clock edge: the register captures the pre-edge settled DataWr.
- No arithmetic is performed; all widths pass through unchanged, with no sign or zero extension.

Optional Feature:
Macro RUDATAWR_STATS_EN.
- When defined, adds four 32-bit output counters: CntAlu, CntMem, CntPc, CntRsv. On each posedge with RUWr=1, the counter matching RUDataWrSrc increments by 1. Counters wrap from 0xFFFF_FFFF to 0 and reset asynchronously to 0.
- When undefined, these ports and registers do not exist, and the remaining behaviour is identical.

Test Plan:
- Set PC_with_offset=0x40, DataRd=0xCAFEBABE, ALURes=0x12345678; sweep select 00/01/10/11, checking 1 ns after each change. DataWr must read 0x12345678, 0xCAFEBABE, 0x00000040, 0x00000000 respectively, with no clock toggling.
- Apply select=01, RUWr=1, rd=5, then a posedge -> WbData_q=0xCAFEBABE, WbRd_q=5, WbValid_q=1.
- Apply RUWr=1, rd=0, select=00, then a posedge -> WbValid_q=0 and WbData_q=0x12345678.
- Apply RUWr=1, select=11, then a posedge -> SelErr_q=1. It stays 1 after subsequent legal selects until rst pulses.
- Assert rst between clock edges -> all _q outputs go to 0 immediately, while DataWr still tracks the select.
- With RUDATAWR_STATS_EN defined: give 3 cycles with select 10 and RUWr=1, plus 1 cycle with RUWr=0 -> CntPc=3 and the other counters 0.
